// File: rtl/motor_ramp_pkg.sv
// Shared definitions for the motor_ramp slew limiter.
//  SPD_W         : width of every motor speed / target
//  ramp_state_t  : sequencer states (OFF, RAMP, TRACK)
//  clamp_spd()   : saturate a requested speed to a ceiling
package motor_ramp_pkg;

  localparam int SPD_W = 11;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    RAMP  = 2'd1,
    TRACK = 2'd2
  } ramp_state_t;

  function automatic logic [SPD_W-1:0] clamp_spd(input logic [SPD_W-1:0] x,
                                                 input logic [SPD_W-1:0] lim);
    return (x > lim) ? lim : x;
  endfunction

endpackage

// File: rtl/motor_slew_ch.sv
// One slew-limited speed channel.
//  clk, rst_n : clock, synchronous active-low reset
//  vld        : latch tgt_in (saturated to MAX_SPD) as the new target
//  tgt_in     : requested speed
//  clr        : force the output speed to 0 (has priority over stepping)
//  step_en    : take one slew step toward the target this cycle
//  fast       : use RUN_STEP instead of START_STEP for upward steps
//  spd        : current slewed speed
//  eq         : spd equals the latched target
module motor_slew_ch
  import motor_ramp_pkg::*;
#(
  parameter int               START_STEP = 2,
  parameter int               RUN_STEP   = 16,
  parameter int               DN_STEP    = 32,
  parameter logic [SPD_W-1:0] MAX_SPD    = 11'h7FF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vld,
  input  logic [SPD_W-1:0] tgt_in,
  input  logic             clr,
  input  logic             step_en,
  input  logic             fast,
  output logic [SPD_W-1:0] spd,
  output logic             eq
);

  localparam logic [SPD_W-1:0] UP_SLOW = SPD_W'(START_STEP);
  localparam logic [SPD_W-1:0] UP_FAST = SPD_W'(RUN_STEP);
  localparam logic [SPD_W-1:0] DN_LIM  = SPD_W'(DN_STEP);

  logic [SPD_W-1:0]        tgt;
  logic [SPD_W-1:0]        cur;
  logic [SPD_W-1:0]        up_lim;
  logic [SPD_W-1:0]        mag;
  logic [SPD_W-1:0]        nxt;
  logic signed [SPD_W:0]   diff;
  logic signed [SPD_W:0]   diff_neg;

  // One extra bit keeps the difference signed so a step can never wrap;
  // the step is limited to the remaining distance so it never overshoots.
  always_comb begin
    diff     = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    diff_neg = -diff;
    up_lim   = fast ? UP_FAST : UP_SLOW;
    mag      = '0;
    nxt      = cur;
    if (diff > 0) begin
      mag = diff[SPD_W-1:0];
      nxt = cur + ((mag < up_lim) ? mag : up_lim);
    end else if (diff < 0) begin
      mag = diff_neg[SPD_W-1:0];
      nxt = cur - ((mag < DN_LIM) ? mag : DN_LIM);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tgt <= '0;
      cur <= '0;
    end else begin
      if (vld) begin
        tgt <= clamp_spd(tgt_in, MAX_SPD);
      end
      if (clr) begin
        cur <= '0;
      end else if (step_en) begin
        cur <= nxt;
      end
    end
  end

  assign spd = cur;
  assign eq  = (cur == tgt);

endmodule

// File: rtl/motor_ramp.sv
// Slew-rate limiter and soft-start sequencer between the flight controller
// and the four ESCs.
//  clk, rst_n          : clock, synchronous active-low reset
//  vld                 : one-cycle strobe, latch the four speed targets
//  frnt/bck/lft/rght_in: requested speeds
//  motors_off          : force all outputs to 0 and return to OFF
//  frnt/bck/lft/rght_spd: slewed speeds to the ESCs
//  settled             : in TRACK with every output at its target
//  ramping             : in RAMP (soft start)
//
//  state | meaning
//  OFF   | outputs held at 0, tick timer parked
//  RAMP  | soft start, upward steps of START_STEP per tick
//  TRACK | normal operation, upward steps of RUN_STEP per tick
module motor_ramp
  import motor_ramp_pkg::*;
#(
  parameter int               TICK_DIV   = 50000,
  parameter int               START_STEP = 2,
  parameter int               RUN_STEP   = 16,
  parameter int               DN_STEP    = 32,
  parameter logic [SPD_W-1:0] MAX_SPD    = 11'h7FF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vld,
  input  logic [SPD_W-1:0] frnt_in,
  input  logic [SPD_W-1:0] bck_in,
  input  logic [SPD_W-1:0] lft_in,
  input  logic [SPD_W-1:0] rght_in,
  input  logic             motors_off,
  output logic [SPD_W-1:0] frnt_spd,
  output logic [SPD_W-1:0] bck_spd,
  output logic [SPD_W-1:0] lft_spd,
  output logic [SPD_W-1:0] rght_spd,
  output logic             settled,
  output logic             ramping
);

  localparam int               CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(TICK_DIV - 1);

  ramp_state_t      state;
  ramp_state_t      state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic             clr;
  logic             step_en;
  logic             fast;
  logic [3:0]       eq;
  logic             all_eq;

  // Down-counter: CNT_TOP is the first cycle of a period, 0 is the last,
  // so a tick fires TICK_DIV cycles after leaving OFF and every TICK_DIV after.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= CNT_TOP;
    end else if (state == OFF || cnt == '0) begin
      cnt <= CNT_TOP;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick   = (cnt == '0);
  assign all_eq = &eq;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= OFF;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    step_en   = 1'b0;
    fast      = 1'b0;
    settled   = 1'b0;
    ramping   = 1'b0;
    case (state)
      OFF: begin
        clr = 1'b1;
        if (!motors_off) state_nxt = RAMP;
      end
      RAMP: begin
        ramping = 1'b1;
        step_en = tick;
        if (all_eq) state_nxt = TRACK;
      end
      TRACK: begin
        fast    = 1'b1;
        step_en = tick;
        settled = all_eq;
      end
      default: state_nxt = OFF;
    endcase
    // motors_off zeroes the outputs on the very next edge, tick or not.
    if (motors_off) begin
      state_nxt = OFF;
      clr       = 1'b1;
    end
  end

  motor_slew_ch #(
    .START_STEP(START_STEP), .RUN_STEP(RUN_STEP), .DN_STEP(DN_STEP), .MAX_SPD(MAX_SPD)
  ) u_frnt (
    .clk(clk), .rst_n(rst_n), .vld(vld), .tgt_in(frnt_in), .clr(clr),
    .step_en(step_en), .fast(fast), .spd(frnt_spd), .eq(eq[0])
  );

  motor_slew_ch #(
    .START_STEP(START_STEP), .RUN_STEP(RUN_STEP), .DN_STEP(DN_STEP), .MAX_SPD(MAX_SPD)
  ) u_bck (
    .clk(clk), .rst_n(rst_n), .vld(vld), .tgt_in(bck_in), .clr(clr),
    .step_en(step_en), .fast(fast), .spd(bck_spd), .eq(eq[1])
  );

  motor_slew_ch #(
    .START_STEP(START_STEP), .RUN_STEP(RUN_STEP), .DN_STEP(DN_STEP), .MAX_SPD(MAX_SPD)
  ) u_lft (
    .clk(clk), .rst_n(rst_n), .vld(vld), .tgt_in(lft_in), .clr(clr),
    .step_en(step_en), .fast(fast), .spd(lft_spd), .eq(eq[2])
  );

  motor_slew_ch #(
    .START_STEP(START_STEP), .RUN_STEP(RUN_STEP), .DN_STEP(DN_STEP), .MAX_SPD(MAX_SPD)
  ) u_rght (
    .clk(clk), .rst_n(rst_n), .vld(vld), .tgt_in(rght_in), .clr(clr),
    .step_en(step_en), .fast(fast), .spd(rght_spd), .eq(eq[3])
  );

endmodule

// File: tb/tb_motor_ramp.sv
// Testbench for motor_ramp: directed table, corner-case sequences and a
// randomized run against a per-cycle reference model.
module tb_motor_ramp;
  import motor_ramp_pkg::*;

  localparam int TD    = 4;
  localparam int MAXS  = 'h7F0;
  localparam int UP_S  = 2;
  localparam int UP_R  = 16;
  localparam int DN    = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             vld = 1'b0;
  logic             motors_off = 1'b0;
  logic [SPD_W-1:0] frnt_in = '0, bck_in = '0, lft_in = '0, rght_in = '0;
  logic [SPD_W-1:0] frnt_spd, bck_spd, lft_spd, rght_spd;
  logic             settled, ramping;

  always #5 clk = ~clk;

  motor_ramp #(
    .TICK_DIV(TD), .START_STEP(UP_S), .RUN_STEP(UP_R), .DN_STEP(DN), .MAX_SPD(11'h7F0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vld(vld),
    .frnt_in(frnt_in), .bck_in(bck_in), .lft_in(lft_in), .rght_in(rght_in),
    .motors_off(motors_off),
    .frnt_spd(frnt_spd), .bck_spd(bck_spd), .lft_spd(lft_spd), .rght_spd(rght_spd),
    .settled(settled), .ramping(ramping)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input int ef, eb, el, er,
                            input bit es, input bit erp);
    check($sformatf("%s.frnt", name), 64'(frnt_spd), 64'(ef));
    check($sformatf("%s.bck", name), 64'(bck_spd), 64'(eb));
    check($sformatf("%s.lft", name), 64'(lft_spd), 64'(el));
    check($sformatf("%s.rght", name), 64'(rght_spd), 64'(er));
    check($sformatf("%s.settled", name), 64'(settled), 64'(es));
    check($sformatf("%s.ramping", name), 64'(ramping), 64'(erp));
  endtask

  // All tasks start and finish just after a falling edge.
  task automatic wait_change(input int budget, output bit changed);
    logic [43:0] p;
    p = {frnt_spd, bck_spd, lft_spd, rght_spd};
    changed = 1'b0;
    for (int i = 0; i < budget && !changed; i++) begin
      @(posedge clk);
      @(negedge clk);
      if ({frnt_spd, bck_spd, lft_spd, rght_spd} !== p) changed = 1'b1;
    end
  endtask

  task automatic wait_chk(input string name);
    bit ch;
    wait_change(2 * TD, ch);
    n_chk++;
    if (!ch) begin
      n_fail++;
      $display("FAIL %s: no output change within %0d cycles, expected a step", name, 2 * TD);
    end
  endtask

  task automatic pulse_vld(input int f, b, l, r);
    frnt_in = SPD_W'(f); bck_in = SPD_W'(b); lft_in = SPD_W'(l); rght_in = SPD_W'(r);
    vld = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vld = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    motors_off = 1'b0;
    vld = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
  endtask

  // Directed vectors: optional vld pulse, then wait n output steps
  // (0 = just two cycles), then compare every output.
  typedef struct {
    bit vld;
    int tf, tb, tl, tr;
    int n_chg;
    int ef, eb, el, er;
    bit es, erp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit v, int tf, tb, tl, tr, int n,
                              int ef, eb, el, er, bit es, bit erp);
    vec_t x;
    x.vld = v; x.tf = tf; x.tb = tb; x.tl = tl; x.tr = tr; x.n_chg = n;
    x.ef = ef; x.eb = eb; x.el = el; x.er = er; x.es = es; x.erp = erp;
    return x;
  endfunction

  // Reference model: targets and speeds as plain integers, a tick every TD
  // cycles after leaving OFF, and the sequencing rules applied per cycle.
  int m_tgt[4], m_cur[4];
  int m_phase;
  int m_mode;  // 0 off, 1 soft start, 2 tracking

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin m_tgt[i] = 0; m_cur[i] = 0; end
    m_phase = 0;
    m_mode = 0;
  endtask

  task automatic model_step(input bit r, input bit v, input bit off, input int tin[4]);
    bit tk, alleq;
    int d, up;
    if (!r) begin
      model_reset();
      return;
    end
    tk = (m_mode != 0) && (m_phase == TD - 1);
    alleq = 1'b1;
    for (int i = 0; i < 4; i++) if (m_cur[i] != m_tgt[i]) alleq = 1'b0;
    up = (m_mode == 1) ? UP_S : UP_R;
    for (int i = 0; i < 4; i++) begin
      if (off || m_mode == 0) m_cur[i] = 0;
      else if (tk) begin
        d = m_tgt[i] - m_cur[i];
        if (d > 0) m_cur[i] += imin(d, up);
        else if (d < 0) m_cur[i] -= imin(-d, DN);
      end
    end
    m_phase = (m_mode == 0) ? 0 : (m_phase + 1) % TD;
    if (off) m_mode = 0;
    else if (m_mode == 0) m_mode = 1;
    else if (m_mode == 1 && alleq) m_mode = 2;
    if (v) for (int i = 0; i < 4; i++) m_tgt[i] = imin(tin[i], MAXS);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ch, stop, mono_bad;
    logic [43:0] p;
    int tin[4];
    bit r, v, off_st;
    logic [45:0] exp_v;
    bit all_eq_m;

    // Soft start to 10, track up to 100, then back down to 0 on front.
    tbl.push_back(mk(1, 10, 10, 10, 10, 1,  2,  2,  2,  2, 0, 1));
    tbl.push_back(mk(0,  0,  0,  0,  0, 1,  4,  4,  4,  4, 0, 1));
    tbl.push_back(mk(0,  0,  0,  0,  0, 1,  6,  6,  6,  6, 0, 1));
    tbl.push_back(mk(0,  0,  0,  0,  0, 1,  8,  8,  8,  8, 0, 1));
    tbl.push_back(mk(0,  0,  0,  0,  0, 1, 10, 10, 10, 10, 0, 1));
    tbl.push_back(mk(0,  0,  0,  0,  0, 0, 10, 10, 10, 10, 1, 0));
    tbl.push_back(mk(1, 100, 10, 10, 10, 1, 26, 10, 10, 10, 0, 0));
    tbl.push_back(mk(0,  0,  0,  0,  0, 1, 42, 10, 10, 10, 0, 0));
    tbl.push_back(mk(0,  0,  0,  0,  0, 1, 58, 10, 10, 10, 0, 0));
    tbl.push_back(mk(0,  0,  0,  0,  0, 1, 74, 10, 10, 10, 0, 0));
    tbl.push_back(mk(0,  0,  0,  0,  0, 1, 90, 10, 10, 10, 0, 0));
    tbl.push_back(mk(0,  0,  0,  0,  0, 1, 100, 10, 10, 10, 1, 0));
    tbl.push_back(mk(1,  0, 10, 10, 10, 1, 68, 10, 10, 10, 0, 0));
    tbl.push_back(mk(0,  0,  0,  0,  0, 1, 36, 10, 10, 10, 0, 0));
    tbl.push_back(mk(0,  0,  0,  0,  0, 1,  4, 10, 10, 10, 0, 0));
    tbl.push_back(mk(0,  0,  0,  0,  0, 1,  0, 10, 10, 10, 1, 0));

    @(negedge clk);
    do_reset();
    check_outs("reset", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    foreach (tbl[k]) begin
      if (tbl[k].vld) pulse_vld(tbl[k].tf, tbl[k].tb, tbl[k].tl, tbl[k].tr);
      if (tbl[k].n_chg == 0) begin
        repeat (2) begin @(posedge clk); @(negedge clk); end
      end else begin
        for (int j = 0; j < tbl[k].n_chg; j++) wait_chk($sformatf("vec%0d.wait", k));
      end
      check_outs($sformatf("vec%0d", k), tbl[k].ef, tbl[k].eb, tbl[k].el, tbl[k].er,
                 tbl[k].es, tbl[k].erp);
    end

    // vld on the same edge as a tick: that step still uses the old target.
    pulse_vld(50, 50, 50, 50);
    wait_chk("s6.wait");
    check_outs("s6.first", 16, 26, 26, 26, 0, 0);
    repeat (TD - 1) @(posedge clk);
    @(negedge clk);
    frnt_in = 11'd20; bck_in = 11'd20; lft_in = 11'd20; rght_in = 11'd20;
    vld = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vld = 1'b0;
    check_outs("s6.coincide", 32, 42, 42, 42, 0, 0);
    wait_chk("s6.wait2");
    check_outs("s6.next", 20, 20, 20, 20, 1, 0);

    // Full-scale request saturates at the ceiling and never wraps.
    pulse_vld('h7FF, 'h7FF, 'h7FF, 'h7FF);
    stop = 1'b0;
    mono_bad = 1'b0;
    for (int k = 0; k < 200 && !stop; k++) begin
      p = {frnt_spd, bck_spd, lft_spd, rght_spd};
      wait_change(3 * TD, ch);
      if (!ch) stop = 1'b1;
      else if (frnt_spd < p[43:33] || bck_spd < p[32:22] ||
               lft_spd < p[21:11] || rght_spd < p[10:0]) mono_bad = 1'b1;
    end
    check("s5.monotonic", 64'(mono_bad), 64'd0);
    check_outs("s5.sat", MAXS, MAXS, MAXS, MAXS, 1, 0);
    wait_change(3 * TD, ch);
    check("s5.hold", 64'(ch), 64'd0);

    // motors_off mid-ramp, together with a new target, then restart and reset.
    do_reset();
    rst_n = 1'b1;
    pulse_vld(10, 10, 10, 10);
    for (int j = 0; j < 3; j++) wait_chk("s4.wait");
    check_outs("s4.mid", 6, 6, 6, 6, 0, 1);
    motors_off = 1'b1;
    frnt_in = 11'd1; bck_in = 11'd3; lft_in = 11'd5; rght_in = 11'd7;
    vld = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vld = 1'b0;
    check_outs("s4.off", 0, 0, 0, 0, 0, 0);
    repeat (2 * TD) begin @(posedge clk); @(negedge clk); end
    check_outs("s4.off_hold", 0, 0, 0, 0, 0, 0);
    motors_off = 1'b0;
    wait_chk("s4.restart");
    check_outs("s4.restart", 1, 2, 2, 2, 0, 1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_outs("s4.reset_mid", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Randomized run against the reference model.
    off_st = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      r = (i < 2) ? 1'b0 : ($urandom_range(0, 999) != 0);
      if (off_st) off_st = ($urandom_range(0, 29) != 0);
      else off_st = ($urandom_range(0, 399) == 0);
      v = ($urandom_range(0, 47) == 0);
      for (int c = 0; c < 4; c++)
        tin[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2047))
                                             : int'($urandom_range(0, 60));
      rst_n = r; motors_off = off_st; vld = v;
      frnt_in = SPD_W'(tin[0]); bck_in = SPD_W'(tin[1]);
      lft_in = SPD_W'(tin[2]); rght_in = SPD_W'(tin[3]);
      model_step(r, v, off_st, tin);
      @(posedge clk);
      @(negedge clk);
      all_eq_m = 1'b1;
      for (int c = 0; c < 4; c++) if (m_cur[c] != m_tgt[c]) all_eq_m = 1'b0;
      exp_v = {SPD_W'(m_cur[0]), SPD_W'(m_cur[1]), SPD_W'(m_cur[2]), SPD_W'(m_cur[3]),
               (m_mode == 2) && all_eq_m, m_mode == 1};
      check($sformatf("rand.cyc%0d", i),
            64'({frnt_spd, bck_spd, lft_spd, rght_spd, settled, ramping}), 64'(exp_v));
    end
    vld = 1'b0;
    motors_off = 1'b0;
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
